// File: rtl/cpu_mem_responder_pkg.sv
// cpu_mem_pkg: shared types and widths for the CPU memory responder.
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int DEF_DATA_W = 16;
  localparam int WAIT_W = 4;
  localparam int STAT_W = 16;
endpackage

// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: request/response bus between CPU initiator and memory responder.
interface cpu_mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic req_valid;
  logic req_ready;
  logic req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic resp_valid;
  logic resp_ready;
  logic resp_err;
  logic [DATA_W-1:0] resp_rdata;
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, resp_ready,
    input req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input req_valid, req_wr, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/cpu_mem_responder_mem_array_sp.sv
// mem_array_sp: single-port RAM with synchronous write and enabled synchronous read.
module mem_array_sp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256
) (
  input  logic clk,
  input  logic en,
  input  logic we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: wait-state memory responder; MEM_STATS_EN adds saturating read/write counters.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  cpu_mem_responder_if.slave bus,
  output logic [STAT_W-1:0] stat_reads,
  output logic [STAT_W-1:0] stat_writes
);
  state_e state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d, rd_ok_q, rd_ok_d;
  logic [ADDR_W-1:0] addr_q, addr_d, c_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, c_wdata, ram_rdata;
  logic accept, commit, hs, c_wr, in_range;
  // With zero wait states the commit edge is the accept edge, so bus fields feed the RAM directly.
  always_comb begin
    accept = state_q == IDLE && bus.req_valid;
    hs = state_q == RESP && bus.resp_ready;
    c_addr = state_q == IDLE ? bus.req_addr : addr_q;
    c_wr = state_q == IDLE ? bus.req_wr : wr_q;
    c_wdata = state_q == IDLE ? bus.req_wdata : wdata_q;
    in_range = int'(c_addr) < DEPTH;
    commit = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == WAIT_W'(1));
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    err_d = err_q;
    rd_ok_d = rd_ok_q;
    if (accept) begin
      wr_d = bus.req_wr;
      addr_d = bus.req_addr;
      wdata_d = bus.req_wdata;
      cnt_d = WAIT_W'(WAIT_CYCLES);
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
    end
    if (state_q == WAIT) begin
      cnt_d = cnt_q - WAIT_W'(1);
      state_d = cnt_q == WAIT_W'(1) ? RESP : WAIT;
    end
    if (commit) begin
      err_d = !in_range;
      rd_ok_d = !c_wr && in_range;
    end
    if (hs) begin
      state_d = IDLE;
      err_d = 1'b0;
      rd_ok_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  mem_array_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .en(commit && in_range),
    .we(c_wr),
    .addr(c_addr),
    .wdata(c_wdata),
    .rdata(ram_rdata)
  );
  assign bus.req_ready = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_err = err_q;
  assign bus.resp_rdata = rd_ok_q ? ram_rdata : '0;
`ifdef MEM_STATS_EN
  logic [STAT_W-1:0] stat_reads_q, stat_reads_d, stat_writes_q, stat_writes_d;
  always_comb begin
    stat_reads_d = stat_reads_q + STAT_W'(hs && !wr_q && stat_reads_q != '1);
    stat_writes_d = stat_writes_q + STAT_W'(hs && wr_q && stat_writes_q != '1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_reads_q <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_reads_q <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  assign stat_reads = stat_reads_q;
  assign stat_writes = stat_writes_q;
`else
  assign stat_reads = '0;
  assign stat_writes = '0;
`endif
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed checks on three responders (0, 1 and 3 wait states; the 1-wait one has DEPTH=200).
module tb_cpu_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rv = '0;
  logic wr = 1'b0, resp_ready = 1'b0;
  logic [7:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [2:0] vld, rdy, err;
  logic [15:0] rdat [3];
  logic [15:0] sr [3];
  logic [15:0] sw [3];
  int checks = 0, errors = 0;
  cpu_mem_responder_if bi [3] ();
  for (genvar i = 0; i < 3; i++) begin : g
    assign bi[i].req_valid = rv[i];
    assign bi[i].req_wr = wr;
    assign bi[i].req_addr = addr;
    assign bi[i].req_wdata = wdata;
    assign bi[i].resp_ready = resp_ready;
    assign vld[i] = bi[i].resp_valid;
    assign rdy[i] = bi[i].req_ready;
    assign err[i] = bi[i].resp_err;
    assign rdat[i] = bi[i].resp_rdata;
    cpu_mem_responder #(
      .DEPTH(i == 1 ? 200 : 256),
      .WAIT_CYCLES(i == 0 ? 0 : (i == 1 ? 1 : 3))
    ) u (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bi[i]),
      .stat_reads(sr[i]),
      .stat_writes(sw[i])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input int s, input logic w, input logic [7:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd, input logic exp_err, input int lat, input int stall);
    int n = 0;
    @(negedge clk);
    wr = w; addr = a; wdata = d; rv[s] = 1'b1;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        rv[s] = 1'b0; wr = ~w; addr = ~a; wdata = ~d;
      end
    end while (!vld[s] && n < 40);
    chk("latency", n, lat);
    chk("rdata", rdat[s], exp_rd);
    chk("err", err[s], exp_err);
    chk("busy_ready", rdy[s], 0);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", vld[s], 1);
      chk("stall_rdata", rdat[s], exp_rd);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("idle_valid", vld[s], 0);
    chk("idle_ready", rdy[s], 1);
    chk("idle_rdata", rdat[s], 0);
    chk("idle_err", err[s], 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", vld, 3'b000);
    chk("rst_ready", rdy, 3'b111);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdata", rdat[1], 0);
    chk("rst_err", err[1], 0);
    txn(1, 1'b1, 8'h05, 16'hBEEF, 16'h0000, 1'b0, 2, 0);
    txn(1, 1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0, 2, 0);
    txn(1, 1'b1, 8'h10, 16'h7777, 16'h0000, 1'b0, 2, 0);
    txn(1, 1'b0, 8'h10, 16'h0000, 16'h7777, 1'b0, 2, 5);
    txn(1, 1'b1, 8'hC7, 16'h4321, 16'h0000, 1'b0, 2, 0);
    txn(1, 1'b1, 8'hC8, 16'h1234, 16'h0000, 1'b1, 2, 0);
    txn(1, 1'b0, 8'hC8, 16'h0000, 16'h0000, 1'b1, 2, 0);
    txn(1, 1'b0, 8'hC7, 16'h0000, 16'h4321, 1'b0, 2, 0);
`ifdef MEM_STATS_EN
    chk("stat_reads", sr[1], 4);
    chk("stat_writes", sw[1], 4);
    @(negedge clk);
    force g[1].u.stat_reads_q = 16'hFFFE;
    #1 release g[1].u.stat_reads_q;
    repeat (3) txn(1, 1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0, 2, 0);
    chk("stat_reads_sat", sr[1], 16'hFFFF);
    chk("stat_writes_hold", sw[1], 4);
`else
    chk("stat_reads_tied", sr[1], 0);
    chk("stat_writes_tied", sw[1], 0);
`endif
    @(negedge clk);
    wr = 1'b1; addr = 8'h20; wdata = 16'h1111; rv[0] = 1'b1;
    @(posedge clk); #1;
    chk("b2b_lat", vld[0], 1);
    chk("b2b_busy", rdy[0], 0);
    wr = 1'b0; wdata = 16'hFFFF;
    @(posedge clk); #1;
    chk("b2b_hold_valid", vld[0], 1);
    chk("b2b_hold_busy", rdy[0], 0);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("b2b_hs_valid", vld[0], 0);
    chk("b2b_hs_ready", rdy[0], 1);
    @(posedge clk); #1;
    chk("b2b_second_valid", vld[0], 1);
    chk("b2b_second_rdata", rdat[0], 16'h1111);
    rv[0] = 1'b0;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("b2b_done", vld[0], 0);
    txn(2, 1'b1, 8'h01, 16'h5555, 16'h0000, 1'b0, 4, 0);
    @(negedge clk);
    wr = 1'b1; addr = 8'h01; wdata = 16'h00AA; rv[2] = 1'b1;
    @(posedge clk); #1; rv[2] = 1'b0;
    chk("abort_wait_busy", rdy[2], 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_rst_ready", rdy[2], 1);
    chk("abort_rst_valid", vld[2], 0);
    @(negedge clk); rst_n = 1'b1;
    txn(2, 1'b0, 8'h01, 16'h0000, 16'h5555, 1'b0, 4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
